// File: rtl/conv3x3_mac_relu.sv
// conv3x3_mac_relu: 3x3 kernel MAC with bias, saturation and optional ReLU, 5-register pipeline
module conv3x3_mac_relu #(
  parameter int DATA_WIDHT = 32,
  parameter int FRAC_BITS  = 16,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Weight_In,
  input  logic                  Weight_Valid,
  input  logic [DATA_WIDHT-1:0] Data_In1,
  input  logic [DATA_WIDHT-1:0] Data_In2,
  input  logic [DATA_WIDHT-1:0] Data_In3,
  input  logic [DATA_WIDHT-1:0] Data_In4,
  input  logic [DATA_WIDHT-1:0] Data_In5,
  input  logic [DATA_WIDHT-1:0] Data_In6,
  input  logic [DATA_WIDHT-1:0] Data_In7,
  input  logic [DATA_WIDHT-1:0] Data_In8,
  input  logic [DATA_WIDHT-1:0] Data_In9,
  input  logic                  Valid_In,
  output logic                  Ready,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Sat_Flag
);
  localparam int PW = 2 * DATA_WIDHT;
  localparam int SW = PW + 4;
  localparam logic signed [SW-1:0] MAX_V = SW'($signed({1'b0, {(DATA_WIDHT-1){1'b1}}}));
  localparam logic signed [SW-1:0] MIN_V = SW'($signed({1'b1, {(DATA_WIDHT-1){1'b0}}}));
  typedef enum logic {LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic signed [DATA_WIDHT-1:0] w_q [10];
  logic signed [DATA_WIDHT-1:0] w_d [10];
  logic signed [DATA_WIDHT-1:0] din [9];
  logic signed [PW-1:0] p_q [9];
  logic signed [PW-1:0] p_d [9];
  logic signed [PW-1:0] b_q, b_d;
  logic signed [SW-1:0] s_q [5];
  logic signed [SW-1:0] s_d [5];
  logic signed [SW-1:0] t_q, t_d;
  logic [DATA_WIDHT-1:0] r_q, r_d, data_out_q, data_out_d;
  logic [4:0] v_q, v_d;
  logic sf_q, sf_d, sat_q, sat_d, accept;

  assign din = '{Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
                 Data_In6, Data_In7, Data_In8, Data_In9};
  assign accept    = Valid_In & Ready;
  assign Data_Out  = data_out_q;
  assign Valid_Out = v_q[4];
  assign Sat_Flag  = sat_q;

  // FSM state, load counter and kernel/bias registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      w_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end

  // next state: serial kernel load, any write while running restarts the load at W0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    if (Weight_Valid && state_q == RUN) begin
      w_d[0]  = Weight_In;
      cnt_d   = 4'd1;
      state_d = LOAD;
    end else if (Weight_Valid) begin
      w_d[cnt_q] = Weight_In;
      cnt_d      = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
      state_d    = (cnt_q == 4'd9) ? RUN : LOAD;
    end
  end

  // FSM output: windows are accepted only with a complete kernel
  always_comb Ready = (state_q == RUN);

  // datapath: products, partial sums, total, saturation, ReLU/hold
  always_comb begin
    for (int i = 0; i < 9; i++) p_d[i] = (PW'(din[i]) * PW'(w_q[i])) >>> FRAC_BITS;
    b_d = PW'(w_q[9]);
    for (int i = 0; i < 4; i++) s_d[i] = SW'(p_q[2*i]) + SW'(p_q[2*i+1]);
    s_d[4] = SW'(p_q[8]) + SW'(b_q);
    t_d = s_q[0] + s_q[1] + s_q[2] + s_q[3] + s_q[4];
    sf_d = (t_q > MAX_V) || (t_q < MIN_V);
    r_d = (t_q > MAX_V) ? MAX_V[DATA_WIDHT-1:0] :
          (t_q < MIN_V) ? MIN_V[DATA_WIDHT-1:0] : t_q[DATA_WIDHT-1:0];
    v_d = {v_q[3:0], accept};
    sat_d = v_q[3] & sf_q;
    data_out_d = !v_q[3] ? data_out_q : (RELU_EN && r_q[DATA_WIDHT-1]) ? '0 : r_q;
  end

  // pipeline registers; valid bits travel with their data
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q        <= '{default: '0};
      b_q        <= '0;
      s_q        <= '{default: '0};
      t_q        <= '0;
      r_q        <= '0;
      sf_q       <= 1'b0;
      v_q        <= '0;
      sat_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      p_q        <= p_d;
      b_q        <= b_d;
      s_q        <= s_d;
      t_q        <= t_d;
      r_q        <= r_d;
      sf_q       <= sf_d;
      v_q        <= v_d;
      sat_q      <= sat_d;
      data_out_q <= data_out_d;
    end
  end
endmodule
